xillybus_loop_fifo: RTL and testbench

//  Parametrised loopback FIFO joining one xillybus host-to-FPGA stream (user_w_*) to one FPGA-to-host

---
 rtl/xillybus_loop_fifo.sv | 171 +++++++++++++++++
 tb/tb_xillybus_loop_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_loop_fifo.sv
// Purpose: loopback FIFO joining one xillybus write stream (user_w_*) to one read stream (user_r_*),
//          with EOF generation, auto-flush when both files close, fill level and sticky overrun.
// Latency: read data registered one edge after an accepted rden; full/empty/fill update one edge after the strobe.
// Backpressure: user_w_full stops the writer (writes while full are dropped and set overrun);
//               user_r_empty stops the reader (reads while empty are ignored).
// Ports:
//   bus_clk, bus_rst            clock, synchronous active-high reset
//   user_w_wren/_data/_open     write strobe, write word, host write file open
//   user_w_full                 FIFO cannot accept a word
//   user_r_rden/_open           read strobe, host read file open
//   user_r_data/_empty/_eof     registered read word, no word available, end-of-file to reader
//   fill_level, overrun         words stored (0..DEPTH), sticky write-while-full flag
module xillybus_loop_fifo #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter bit EOF_ENABLE = 1'b1
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              user_w_wren,
    input  logic [DATA_W-1:0] user_w_data,
    input  logic              user_w_open,
    output logic              user_w_full,
    input  logic              user_r_rden,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_empty,
    output logic              user_r_eof,
    input  logic              user_r_open,
    output logic [ADDR_W:0]   fill_level,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [ADDR_W:0] fill_nxt;
    logic            wr_acc;
    logic            rd_acc;
    logic            both_closed;
    logic            closed_seen;
    logic            flush;

    // Accept decisions use only the registered flags, so a read freeing a slot
    // in the same cycle never lets a write into a FIFO that was full.
    always_comb begin
        both_closed = !user_w_open && !user_r_open;
        flush       = both_closed && closed_seen;
        wr_acc      = user_w_wren && !user_w_full;
        rd_acc      = user_r_rden && !user_r_empty;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_nxt = wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_nxt = rd_ptr + 1'b1;
            end
        end
        // Pointers carry one wrap bit, so the modulo difference is the exact count 0..DEPTH.
        fill_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge bus_clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr[ADDR_W-1:0]] <= user_w_data;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            user_w_full  <= 1'b0;
            user_r_empty <= 1'b1;
            user_r_data  <= '0;
            overrun      <= 1'b0;
            closed_seen  <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            fill_level   <= fill_nxt;
            user_w_full  <= (fill_nxt == FULL_CNT);
            user_r_empty <= (fill_nxt == '0);
            // Both sides closed on the previous edge too: this edge flushes.
            closed_seen  <= both_closed;
            // Read data survives a flush; only accepted reads replace it.
            if (rd_acc && !flush) begin
                user_r_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
            if (flush) begin
                overrun <= 1'b0;
            end else if (user_w_wren && user_w_full) begin
                overrun <= 1'b1;
            end
        end
    end

    generate
        if (EOF_ENABLE) begin : g_eof
            typedef enum logic [1:0] {
                S_IDLE,
                S_WRITING,
                S_DRAINING,
                S_EOF
            } state_t;

            state_t state;
            state_t state_nxt;

            always_ff @(posedge bus_clk) begin
                if (bus_rst) begin
                    state <= S_IDLE;
                end else begin
                    state <= state_nxt;
                end
            end

            // DRAINING looks at the post-edge fill so EOF rises on the same
            // edge that the last word leaves and empty goes high.
            always_comb begin
                state_nxt = state;
                case (state)
                    S_IDLE: begin
                        if (user_w_open) begin
                            state_nxt = S_WRITING;
                        end
                    end
                    S_WRITING: begin
                        if (!user_w_open) begin
                            state_nxt = S_DRAINING;
                        end
                    end
                    S_DRAINING: begin
                        if (user_w_open) begin
                            state_nxt = S_WRITING;
                        end else if (fill_nxt == '0) begin
                            state_nxt = S_EOF;
                        end
                    end
                    S_EOF: begin
                        if (!user_r_open) begin
                            state_nxt = S_IDLE;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
                if (flush) begin
                    state_nxt = S_IDLE;
                end
            end

            // Both terms are registers: no combinational path from the strobes.
            assign user_r_eof = (state == S_EOF) && user_r_empty;
        end else begin : g_no_eof
            assign user_r_eof = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_xillybus_loop_fifo.sv
module tb_xillybus_loop_fifo;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              bus_clk = 1'b0;
    logic              bus_rst = 1'b1;
    logic              user_w_wren = 1'b0;
    logic [DATA_W-1:0] user_w_data = '0;
    logic              user_w_open = 1'b1;
    logic              user_w_full;
    logic              user_r_rden = 1'b0;
    logic [DATA_W-1:0] user_r_data;
    logic              user_r_empty;
    logic              user_r_eof;
    logic              user_r_open = 1'b1;
    logic [ADDR_W:0]   fill_level;
    logic              overrun;

    always #5 bus_clk = ~bus_clk;

    xillybus_loop_fifo #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .EOF_ENABLE(1'b1)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_rst     (bus_rst),
        .user_w_wren (user_w_wren),
        .user_w_data (user_w_data),
        .user_w_open (user_w_open),
        .user_w_full (user_w_full),
        .user_r_rden (user_r_rden),
        .user_r_data (user_r_data),
        .user_r_empty(user_r_empty),
        .user_r_eof  (user_r_eof),
        .user_r_open (user_r_open),
        .fill_level  (fill_level),
        .overrun     (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of stored words plus the last word read out.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rdata = '0;
    bit                m_over  = 1'b0;
    int                closed_edges = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".fill"},  64'(fill_level),   64'(q.size()));
        chk({tag, ".full"},  64'(user_w_full),  64'(q.size() == DEPTH));
        chk({tag, ".empty"}, 64'(user_r_empty), 64'(q.size() == 0));
        chk({tag, ".rdata"}, 64'(user_r_data),  64'(m_rdata));
        chk({tag, ".ovr"},   64'(overrun),      64'(m_over));
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata      = '0;
        m_over       = 1'b0;
        closed_edges = 0;
    endtask

    // One clock edge with the given strobes, then model update and output check.
    task automatic step(input bit wr, input logic [DATA_W-1:0] wd, input bit rd, input string tag);
        bit was_full;
        bit was_empty;
        user_w_wren = wr;
        user_w_data = wd;
        user_r_rden = rd;
        @(posedge bus_clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (!user_w_open && !user_r_open) closed_edges++;
        else closed_edges = 0;
        if (closed_edges >= 2) begin
            q.delete();
            m_over = 1'b0;
        end else begin
            if (rd && !was_empty) m_rdata = q.pop_front();
            if (wr) begin
                if (was_full) m_over = 1'b1;
                else q.push_back(wd);
            end
        end
        #1;
        user_w_wren = 1'b0;
        user_r_rden = 1'b0;
        chk_model(tag);
    endtask

    task automatic do_reset(input bit wr_during);
        bus_rst     = 1'b1;
        user_w_wren = wr_during;
        user_w_data = $urandom;
        user_r_rden = 1'b0;
        @(posedge bus_clk);
        #1;
        bus_rst     = 1'b0;
        user_w_wren = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset state
        do_reset(1'b0);
        chk_model("reset");
        chk("reset.eof", 64'(user_r_eof), 64'(0));

        // Basic write then read with fixed words
        step(1'b1, 32'h11, 1'b0, "t1.w0");
        step(1'b1, 32'h22, 1'b0, "t1.w1");
        step(1'b1, 32'h33, 1'b0, "t1.w2");
        chk("t1.fill3", 64'(fill_level), 64'(3));
        step(1'b0, '0, 1'b1, "t1.r0");
        chk("t1.d0", 64'(user_r_data), 64'h11);
        step(1'b0, '0, 1'b1, "t1.r1");
        chk("t1.d1", 64'(user_r_data), 64'h22);
        step(1'b0, '0, 1'b1, "t1.r2");
        chk("t1.d2", 64'(user_r_data), 64'h33);
        chk("t1.empty", 64'(user_r_empty), 64'(1));
        step(1'b0, '0, 1'b1, "t1.r_empty");

        // Fill to full, overflow by one, drain across the wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, "t2.fill");
        chk("t2.full", 64'(user_w_full), 64'(1));
        step(1'b1, $urandom, 1'b0, "t2.over");
        chk("t2.ovr", 64'(overrun), 64'(1));
        step(1'b1, $urandom, 1'b1, "t2.rw_full");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "t2.drain");
        chk("t2.ovr_sticky", 64'(overrun), 64'(1));

        // Steady half fill with simultaneous read and write
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, "t3.pre");
        for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, "t3.rw");
        chk("t3.fill8", 64'(fill_level), 64'(8));

        // Random traffic
        for (int i = 0; i < 300; i++) step(1'($urandom), $urandom, 1'($urandom), "rand");
        while (q.size() != 0) step(1'b0, '0, 1'b1, "rand.drain");

        // EOF after write close and drain
        step(1'b1, $urandom, 1'b0, "t4.w0");
        step(1'b1, $urandom, 1'b0, "t4.w1");
        user_w_open = 1'b0;
        step(1'b0, '0, 1'b0, "t4.close");
        chk("t4.eof_a", 64'(user_r_eof), 64'(0));
        step(1'b0, '0, 1'b1, "t4.r0");
        chk("t4.eof_b", 64'(user_r_eof), 64'(0));
        step(1'b0, '0, 1'b1, "t4.r1");
        chk("t4.eof_c", 64'(user_r_eof), 64'(1));
        step(1'b0, '0, 1'b1, "t4.r_at_eof");
        chk("t4.eof_d", 64'(user_r_eof), 64'(1));
        user_r_open = 1'b0;
        step(1'b0, '0, 1'b0, "t4.rclose");
        chk("t4.eof_e", 64'(user_r_eof), 64'(0));
        user_w_open = 1'b1;
        user_r_open = 1'b1;
        step(1'b0, '0, 1'b0, "t4.reopen");
        chk("t4.eof_f", 64'(user_r_eof), 64'(0));

        // Flush when both sides close: fill 5 with overrun set
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, $urandom, 1'b0, "t5.fill");
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, "t5.read");
        chk("t5.fill5", 64'(fill_level), 64'(5));
        user_w_open = 1'b0;
        user_r_open = 1'b0;
        step(1'b0, '0, 1'b0, "t5.edge1");
        chk("t5.fill_kept", 64'(fill_level), 64'(5));
        step(1'b0, '0, 1'b0, "t5.edge2");
        chk("t5.fill0", 64'(fill_level), 64'(0));
        chk("t5.ovr0", 64'(overrun), 64'(0));
        chk("t5.eof", 64'(user_r_eof), 64'(0));
        step(1'b0, '0, 1'b0, "t5.edge3");

        // Reset mid-burst while draining
        user_w_open = 1'b1;
        user_r_open = 1'b1;
        step(1'b0, '0, 1'b0, "t6.open");
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, "t6.w");
        user_w_open = 1'b0;
        step(1'b0, '0, 1'b0, "t6.close");
        chk("t6.fill7", 64'(fill_level), 64'(7));
        chk("t6.eof_drain", 64'(user_r_eof), 64'(0));
        do_reset(1'b1);
        chk_model("t6.reset");
        chk("t6.eof_rst", 64'(user_r_eof), 64'(0));
        user_w_open = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, "t6.w2");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "t6.r2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
